// File: rtl/jtag_seq_parser.sv
// Frames the MCU command byte stream into one out_seq FIFO entry per command.
// Illegal opcodes are dropped and packets stalled mid-payload are aborted.
`ifndef JTAG_FIFO_CMD_DEFINES
`define JTAG_FIFO_CMD_DEFINES
`define FIFO_CMD_WR      5'd1
`define FIFO_CMD_STORE   5'd2
`define FIFO_CMD_EXECUTE 5'd3
`define FIFO_CMD_FLUSH   5'd4
`endif

module jtag_seq_parser #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  input  logic             seq_full,
  output logic             seq_we,
  output logic [4:0]       seq_command,
  output logic [7:0]       seq_tms,
  output logic [7:0]       seq_tdi,
  output logic [2:0]       seq_bits,
  output logic [7:0]       seq_read,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int unsigned TO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_WR      = 3'd0;
  localparam logic [2:0] OP_STORE   = 3'd1;
  localparam logic [2:0] OP_EXECUTE = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_PUSH
  } state_t;

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [1:0]      r_len;
  logic [TO_W-1:0] r_idle_cnt;

  logic            w_accept;
  logic            w_legal;
  logic            w_last;
  logic [2:0]      w_op;
  logic [1:0]      w_plen;
  logic [4:0]      w_cmd;
  logic [TO_W-1:0] w_idle_next;
  logic            w_unused;

  // Ready only depends on state, so a stalled PUSH backpressures the link.
  assign rx_ready    = ~rst && (r_state != S_PUSH);
  assign w_accept    = rx_valid && rx_ready;
  assign w_op        = rx_data[7:5];
  assign w_legal     = ~w_op[2];
  assign w_last      = (r_idx + 2'd1) == r_len;
  assign w_idle_next = r_idle_cnt + TO_W'(1);
  assign w_unused    = ^rx_data[4:3];

  // Opcode decode: payload length and FIFO command code.
  always_comb begin
    w_plen = 2'd0;
    w_cmd  = `FIFO_CMD_FLUSH;
    case (w_op)
      OP_WR: begin
        w_plen = 2'd3;
        w_cmd  = `FIFO_CMD_WR;
      end
      OP_STORE: begin
        w_plen = 2'd2;
        w_cmd  = `FIFO_CMD_STORE;
      end
      OP_EXECUTE: w_cmd = `FIFO_CMD_EXECUTE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_len       <= 2'd0;
      r_idle_cnt  <= '0;
      seq_we      <= 1'b0;
      seq_command <= 5'd0;
      seq_tms     <= 8'd0;
      seq_tdi     <= 8'd0;
      seq_bits    <= 3'd0;
      seq_read    <= 8'd0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      cmd_count   <= '0;
    end else begin
      seq_we      <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_legal) begin
              err_illegal <= 1'b1;
            end else begin
              // Fields are cleared on every header so unused ones read as 0.
              seq_command <= w_cmd;
              seq_bits    <= (w_op == OP_WR) ? rx_data[2:0] : 3'd0;
              seq_tms     <= 8'd0;
              seq_tdi     <= 8'd0;
              seq_read    <= 8'd0;
              r_idx       <= 2'd0;
              r_len       <= w_plen;
              r_idle_cnt  <= '0;
              r_state     <= (w_plen == 2'd0) ? S_PUSH : S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            case (r_idx)
              2'd0:    seq_tms  <= rx_data;
              2'd1:    seq_tdi  <= rx_data;
              default: seq_read <= rx_data;
            endcase
            r_idx      <= r_idx + 2'd1;
            r_idle_cnt <= '0;
            if (w_last) r_state <= S_PUSH;
          end else if (TIMEOUT != 0) begin
            if (w_idle_next == TO_W'(TIMEOUT)) begin
              err_timeout <= 1'b1;
              r_idle_cnt  <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_idle_cnt <= w_idle_next;
            end
          end
        end
        S_PUSH: begin
          if (!seq_full) begin
            seq_we    <= 1'b1;
            cmd_count <= cmd_count + CNT_W'(1);
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_seq_parser.sv
// Bench for jtag_seq_parser: directed scenarios then random packets, checked
// against a packet-level model and an expected-entry queue.
module tb_jtag_seq_parser;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CNT_W   = 16;

  localparam logic [4:0] C_WR    = 5'd1;
  localparam logic [4:0] C_STORE = 5'd2;
  localparam logic [4:0] C_EXEC  = 5'd3;
  localparam logic [4:0] C_FLUSH = 5'd4;

  typedef struct packed {
    logic [4:0] cmd;
    logic [7:0] tms;
    logic [7:0] tdi;
    logic [2:0] bits;
    logic [7:0] rd;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'd0;
  logic             seq_full = 1'b0;
  logic             rx_ready, seq_we, err_illegal, err_timeout;
  logic [4:0]       seq_command;
  logic [7:0]       seq_tms, seq_tdi, seq_read;
  logic [2:0]       seq_bits;
  logic [CNT_W-1:0] cmd_count;

  logic             rx_ready_b, seq_we_b, err_illegal_b, err_timeout_b;
  logic [4:0]       seq_command_b;
  logic [7:0]       seq_tms_b, seq_tdi_b, seq_read_b;
  logic [2:0]       seq_bits_b;
  logic [2:0]       cmd_count_b;

  int errors = 0;
  int checks = 0;
  int exp_ill = 0, exp_to = 0, seen_ill = 0, seen_to = 0;
  int exp_cnt = 0;
  int full_mode = 0;
  entry_t exp_q[$];

  jtag_seq_parser #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .seq_full(seq_full), .seq_we(seq_we),
    .seq_command(seq_command), .seq_tms(seq_tms), .seq_tdi(seq_tdi),
    .seq_bits(seq_bits), .seq_read(seq_read), .err_illegal(err_illegal),
    .err_timeout(err_timeout), .cmd_count(cmd_count)
  );

  // Narrow counter copy to observe wrap-around.
  jtag_seq_parser #(.TIMEOUT(TIMEOUT), .CNT_W(3)) dut_wrap (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready_b), .seq_full(seq_full), .seq_we(seq_we_b),
    .seq_command(seq_command_b), .seq_tms(seq_tms_b), .seq_tdi(seq_tdi_b),
    .seq_bits(seq_bits_b), .seq_read(seq_read_b), .err_illegal(err_illegal_b),
    .err_timeout(err_timeout_b), .cmd_count(cmd_count_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int plen(input logic [2:0] op);
    case (op)
      3'd0:    return 3;
      3'd1:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic entry_t model(input logic [7:0] hdr, input logic [7:0] p0,
                                   input logic [7:0] p1, input logic [7:0] p2);
    entry_t e;
    e = '0;
    case (hdr[7:5])
      3'd0: begin e.cmd = C_WR; e.tms = p0; e.tdi = p1; e.rd = p2; e.bits = hdr[2:0]; end
      3'd1: begin e.cmd = C_STORE; e.tms = p0; e.tdi = p1; end
      3'd2: e.cmd = C_EXEC;
      3'd3: e.cmd = C_FLUSH;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] dut_entry();
    return {seq_command, seq_tms, seq_tdi, seq_bits, seq_read};
  endfunction

  task automatic check_reset(input string tag);
    check_eq({tag, "_ctl"}, 32'({seq_we, err_illegal, err_timeout, rx_ready, seq_command, seq_bits}), 32'd0);
    check_eq({tag, "_fields"}, 32'({seq_tms, seq_tdi, seq_read}), 32'd0);
    check_eq({tag, "_count"}, 32'(cmd_count), 32'd0);
  endtask

  // seq_full driver: 0 = free, 1 = full, 2 = random backpressure.
  initial forever begin
    @(negedge clk);
    #1;
    if (full_mode == 0)      seq_full = 1'b0;
    else if (full_mode == 1) seq_full = 1'b1;
    else                     seq_full = ($urandom_range(9, 0) < 3);
  end

  // Scoreboard: every FIFO write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_illegal) seen_ill++;
      if (err_timeout) seen_to++;
      if (seq_we) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_we", 32'd1, 32'd0);
        end else begin
          check_eq("entry", dut_entry(), 32'(exp_q.pop_front()));
          exp_cnt++;
          check_eq("cmd_count", 32'(cmd_count), 32'(exp_cnt) & 32'hFFFF);
          check_eq("cmd_count_wrap", 32'(cmd_count_b), 32'(exp_cnt) & 32'h7);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 400; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
    end
    check_eq("rx_ready_wait", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic idle_edges(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input int maxgap, input int abort_at);
    logic [7:0] p [3];
    int n;
    int g;
    p[0] = p0; p[1] = p1; p[2] = p2;
    n = plen(hdr[7:5]);
    send_byte(hdr);
    if (hdr[7]) begin
      exp_ill++;
      rx_valid = 1'b0;
      return;
    end
    if (n == 0) exp_q.push_back(model(hdr, p0, p1, p2));
    for (int i = 0; i < n; i++) begin
      if (abort_at == i) begin
        idle_edges(TIMEOUT - 1);
        @(negedge clk);
        check_eq("no_early_timeout", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;
        exp_to++;
        return;
      end
      g = $urandom_range(maxgap, 0);
      if (g > 0) idle_edges(g);
      if (i == n - 1) exp_q.push_back(model(hdr, p0, p1, p2));
      send_byte(p[i]);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    check_eq("drain_wait", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] hdr;
    int n, ab, mg;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    // WR with latency check
    send_pkt(8'h05, 8'hA5, 8'h3C, 8'hFF, 0, -1);
    @(negedge clk);
    check_eq("wr_we_push", 32'(seq_we), 32'd0);
    check_eq("wr_ready_push", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check_eq("wr_we", 32'(seq_we), 32'd1);
    check_eq("wr_count", 32'(cmd_count), 32'd1);
    @(negedge clk);
    check_eq("wr_we_single", 32'(seq_we), 32'd0);

    // STORE then EXECUTE
    send_pkt(8'h20, 8'h12, 8'h00, 8'h00, 0, -1);
    send_pkt(8'h40, 8'h00, 8'h00, 8'h00, 0, -1);
    wait_drain();
    @(negedge clk);
    check_eq("se_count", 32'(cmd_count), 32'd3);

    // FLUSH held by backpressure for 10 cycles
    full_mode = 1;
    send_pkt(8'h60, 8'h00, 8'h00, 8'h00, 0, -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_ready", 32'(rx_ready), 32'd0);
      check_eq("bp_we", 32'(seq_we), 32'd0);
      check_eq("bp_fields", dut_entry(), 32'(model(8'h60, 8'h00, 8'h00, 8'h00)));
    end
    full_mode = 0;
    @(negedge clk);
    check_eq("bp_we_release", 32'(seq_we), 32'd1);

    // Illegal opcode then WR
    send_pkt(8'hE0, 8'h00, 8'h00, 8'h00, 0, -1);
    @(negedge clk);
    check_eq("ill_pulse", 32'(err_illegal), 32'd1);
    check_eq("ill_no_we", 32'(seq_we), 32'd0);
    @(negedge clk);
    check_eq("ill_pulse_end", 32'(err_illegal), 32'd0);
    send_pkt(8'h00, 8'h01, 8'h02, 8'h00, 0, -1);
    wait_drain();

    // Timeout after one payload byte, then FLUSH
    send_pkt(8'h00, 8'h11, 8'h00, 8'h00, 0, 1);
    @(negedge clk);
    check_eq("to_pulse", 32'(err_timeout), 32'd1);
    check_eq("to_no_we", 32'(seq_we), 32'd0);
    check_eq("to_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    check_eq("to_pulse_end", 32'(err_timeout), 32'd0);
    send_pkt(8'h60, 8'h00, 8'h00, 8'h00, 0, -1);
    wait_drain();

    // Asynchronous reset mid-payload
    send_byte(8'h00);
    send_byte(8'h11);
    #2;
    rst = 1'b1;
    rx_valid = 1'b0;
    #1;
    check_reset("midrst");
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send_pkt(8'h07, 8'h5A, 8'hC3, 8'h81, 0, -1);
    wait_drain();
    @(negedge clk);
    check_eq("midrst_count", 32'(cmd_count), 32'd1);

    // Random packets under random backpressure
    full_mode = 2;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(3, 0) == 0) hdr = {3'(4 + $urandom_range(3, 0)), 5'($urandom())};
      else                           hdr = {3'($urandom_range(3, 0)), 5'($urandom())};
      n  = plen(hdr[7:5]);
      ab = ((n > 0) && ($urandom_range(19, 0) == 0)) ? $urandom_range(n - 1, 0) : -1;
      mg = ($urandom_range(3, 0) == 0) ? TIMEOUT - 1 : 0;
      send_pkt(hdr, 8'($urandom()), 8'($urandom()), 8'($urandom()), mg, ab);
      if ($urandom_range(2, 0) == 0) idle_edges($urandom_range(2, 1));
    end
    full_mode = 0;
    wait_drain();
    repeat (3) @(negedge clk);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("illegal_pulses", 32'(seen_ill), 32'(exp_ill));
    check_eq("timeout_pulses", 32'(seen_to), 32'(exp_to));
    check_eq("final_count", 32'(cmd_count), 32'(exp_cnt) & 32'hFFFF);
    check_eq("final_count_wrap", 32'(cmd_count_b), 32'(exp_cnt) & 32'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
